// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: synchronises and deglitches Z80 I/O strobes, queues accesses in order
// and drains them one at a time through a held REQ/ACK port; read data lands on bus_dout.
module cpu_io_bridge #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          csr_n,
    input  logic                          csw_n,
    input  logic [ADDR_WIDTH-1:0]         port_addr,
    input  logic [DATA_WIDTH-1:0]         bus_din,
    output logic [DATA_WIDTH-1:0]         bus_dout,
    output logic                          req,
    output logic                          wrt,
    output logic [ADDR_WIDTH-1:0]         adr,
    output logic [DATA_WIDTH-1:0]         dbo,
    input  logic                          ack,
    input  logic [DATA_WIDTH-1:0]         dbi,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          proto_err
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam int unsigned EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    // Strobe conditioning, bit 0 = read strobe, bit 1 = write strobe
    logic [1:0]         raw;
    logic [1:0]         sync1_q, sync2_q, filt_q, filt_d, prev_q, armed_q, fall;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         settle_q;

    assign raw = {csw_n, csr_n};

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
                else                                  cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Arming waits until the synchroniser holds real samples, so a strobe
    // already low at reset release must go high before it can make an access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            filt_q   <= '1;
            prev_q   <= '1;
            cnt_q    <= '0;
            settle_q <= '0;
            armed_q  <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            prev_q   <= filt_q;
            cnt_q    <= cnt_d;
            settle_q <= {settle_q[0], 1'b1};
            armed_q  <= armed_q | ({2{settle_q[1]}} & sync2_q & filt_q);
        end
    end

    assign fall = armed_q & prev_q & ~filt_q;

    logic          push_req, push_wr, pop, full, empty, push_ok;
    logic [EW-1:0] push_entry, head;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]   wptr_q, rptr_q;

    assign push_req   = fall[0] ^ fall[1];
    assign push_wr    = fall[1];
    assign push_entry = {push_wr, port_addr, bus_din & {DATA_WIDTH{push_wr}}};
    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign push_ok    = push_req && (!full || pop);
    assign head       = mem_q[rptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[PW-1:0]] <= push_entry;
    end

    state_e state_q, state_d;
    logic   wrt_q, overflow_q, proto_err_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dbo_q, bus_dout_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req = 1'b1;
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            wrt_q       <= 1'b0;
            adr_q       <= '0;
            dbo_q       <= '0;
            bus_dout_q  <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
                {wrt_q, adr_q, dbo_q} <= head;
            end
            if (state_q == ISSUE && ack && !wrt_q) bus_dout_q <= dbi;
            if (push_req && full && !pop) overflow_q <= 1'b1;
            if (&fall) proto_err_q <= 1'b1;
        end
    end

    assign wrt        = wrt_q;
    assign adr        = adr_q;
    assign dbo        = dbo_q;
    assign bus_dout   = bus_dout_q;
    assign fifo_level = wptr_q - rptr_q;
    assign overflow   = overflow_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed self-checking bench for cpu_io_bridge at default parameters (FILTER_LEN=3, FIFO_DEPTH=4).
module tb_cpu_io_bridge;

    logic       clk = 1'b0;
    logic       reset, csr_n, csw_n, ack;
    logic [1:0] port_addr, adr;
    logic [7:0] bus_din, bus_dout, dbo, dbi;
    logic       req, wrt, overflow, proto_err;
    logic [2:0] fifo_level;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [10:0] log_q[$];

    always #5 clk = ~clk;

    cpu_io_bridge #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(8),
        .FILTER_LEN(3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .csr_n(csr_n), .csw_n(csw_n),
        .port_addr(port_addr), .bus_din(bus_din), .bus_dout(bus_dout),
        .req(req), .wrt(wrt), .adr(adr), .dbo(dbo), .ack(ack), .dbi(dbi),
        .fifo_level(fifo_level), .overflow(overflow), .proto_err(proto_err)
    );

    // Core-side record of every accepted access: {wrt, adr, dbo}
    always @(negedge clk) begin
        if (req && ack) log_q.push_back({wrt, adr, dbo});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_access(input logic is_wr, input logic [1:0] a, input logic [7:0] d);
        port_addr = a;
        bus_din   = d;
        if (is_wr) csw_n = 1'b0; else csr_n = 1'b0;
        tick(6);
        csw_n = 1'b1;
        csr_n = 1'b1;
        tick(6);
    endtask

    initial begin
        reset = 1'b1; csr_n = 1'b1; csw_n = 1'b1; ack = 1'b0;
        port_addr = '0; bus_din = '0; dbi = '0;
        tick(3);
        check_eq("rst_req",   {31'd0, req}, 0);
        check_eq("rst_wrt",   {31'd0, wrt}, 0);
        check_eq("rst_adr",   {30'd0, adr}, 0);
        check_eq("rst_dbo",   {24'd0, dbo}, 0);
        check_eq("rst_dout",  {24'd0, bus_dout}, 0);
        check_eq("rst_level", {29'd0, fifo_level}, 0);
        check_eq("rst_ovf",   {31'd0, overflow}, 0);
        check_eq("rst_perr",  {31'd0, proto_err}, 0);
        reset = 1'b0;
        tick(6);

        // Single write, ack tied high: req rises at edge 7 for one cycle
        ack = 1'b1; port_addr = 2'd1; bus_din = 8'hA5; csw_n = 1'b0;
        tick(6);
        check_eq("w1_req_e6",   {31'd0, req}, 0);
        check_eq("w1_level_e6", {29'd0, fifo_level}, 1);
        tick(1);
        check_eq("w1_req_e7", {31'd0, req}, 1);
        check_eq("w1_wrt",    {31'd0, wrt}, 1);
        check_eq("w1_adr",    {30'd0, adr}, 1);
        check_eq("w1_dbo",    {24'd0, dbo}, 32'hA5);
        tick(1);
        check_eq("w1_req_e8", {31'd0, req}, 0);
        tick(2);
        csw_n = 1'b1;
        tick(8);
        check_eq("w1_count", log_q.size(), 1);
        log_q.delete();

        // Write then read with ack held low; write must complete first
        ack = 1'b0; dbi = 8'h3C;
        do_access(1'b1, 2'd0, 8'h11);
        do_access(1'b0, 2'd1, 8'hEE);
        check_eq("rw_req",   {31'd0, req}, 1);
        check_eq("rw_wrt",   {31'd0, wrt}, 1);
        check_eq("rw_adr",   {30'd0, adr}, 0);
        check_eq("rw_dbo",   {24'd0, dbo}, 32'h11);
        check_eq("rw_level", {29'd0, fifo_level}, 1);
        tick(5);
        check_eq("rw_hold", {31'd0, req}, 1);
        ack = 1'b1;
        tick(1);
        check_eq("rw_gap",  {31'd0, req}, 0);
        tick(1);
        check_eq("rd_req",  {31'd0, req}, 1);
        check_eq("rd_wrt",  {31'd0, wrt}, 0);
        check_eq("rd_adr",  {30'd0, adr}, 1);
        check_eq("rd_dout_pre", {24'd0, bus_dout}, 0);
        tick(1);
        check_eq("rd_dout", {24'd0, bus_dout}, 32'h3C);
        check_eq("rw_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check_eq("rw_first",  {21'd0, log_q[0]}, {21'd0, 1'b1, 2'd0, 8'h11});
            check_eq("rw_second", {29'd0, log_q[1][10:8]}, {29'd0, 1'b0, 2'd1});
        end
        log_q.delete();
        ack = 1'b0;

        // 2-cycle write glitch is filtered out
        csw_n = 1'b0;
        tick(2);
        csw_n = 1'b1;
        tick(12);
        check_eq("gl_level", {29'd0, fifo_level}, 0);
        check_eq("gl_req",   {31'd0, req}, 0);
        check_eq("gl_count", log_q.size(), 0);

        // Overflow: 1 in flight + 4 queued, sixth dropped
        for (int i = 1; i <= 5; i++) do_access(1'b1, 2'(i % 4), 8'(i));
        check_eq("ov_level5", {29'd0, fifo_level}, 4);
        check_eq("ov_flag5",  {31'd0, overflow}, 0);
        do_access(1'b1, 2'd2, 8'h06);
        check_eq("ov_level6", {29'd0, fifo_level}, 4);
        check_eq("ov_flag6",  {31'd0, overflow}, 1);
        check_eq("ov_dbo",    {24'd0, dbo}, 1);
        ack = 1'b1;
        tick(14);
        check_eq("ov_count", log_q.size(), 5);
        for (int i = 1; i <= 5; i++) begin
            if (log_q.size() >= i)
                check_eq("ov_order", {21'd0, log_q[i-1]}, {21'd0, 1'b1, 2'(i % 4), 8'(i)});
        end
        check_eq("ov_sticky", {31'd0, overflow}, 1);
        check_eq("ov_dout",   {24'd0, bus_dout}, 32'h3C);
        log_q.delete();

        // Both strobes together
        check_eq("pe_before", {31'd0, proto_err}, 0);
        csr_n = 1'b0; csw_n = 1'b0;
        tick(10);
        check_eq("pe_flag",  {31'd0, proto_err}, 1);
        check_eq("pe_req",   {31'd0, req}, 0);
        check_eq("pe_level", {29'd0, fifo_level}, 0);
        csr_n = 1'b1; csw_n = 1'b1;
        tick(8);
        check_eq("pe_count", log_q.size(), 0);

        // Reset during ISSUE with 3 queued, csw_n held low across release
        ack = 1'b0;
        for (int i = 0; i < 4; i++) do_access(1'b1, 2'(i), 8'h40 + 8'(i));
        check_eq("rs_level_pre", {29'd0, fifo_level}, 3);
        check_eq("rs_req_pre",   {31'd0, req}, 1);
        csw_n = 1'b0; port_addr = 2'd3; bus_din = 8'h77;
        tick(1);
        reset = 1'b1;
        #1;
        check_eq("rs_req",   {31'd0, req}, 0);
        check_eq("rs_level", {29'd0, fifo_level}, 0);
        check_eq("rs_ovf",   {31'd0, overflow}, 0);
        check_eq("rs_perr",  {31'd0, proto_err}, 0);
        tick(2);
        reset = 1'b0;
        ack = 1'b1;
        tick(15);
        check_eq("rs_held_level", {29'd0, fifo_level}, 0);
        check_eq("rs_held_count", log_q.size(), 0);
        csw_n = 1'b1;
        tick(8);
        check_eq("rs_rise_count", log_q.size(), 0);
        do_access(1'b1, 2'd2, 8'h5A);
        check_eq("rs_new_count", log_q.size(), 1);
        if (log_q.size() == 1)
            check_eq("rs_new_entry", {21'd0, log_q[0]}, {21'd0, 1'b1, 2'd2, 8'h5A});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_io_bridge.md
# cpu_io_bridge

Parametrised Z80-side I/O bridge between the raw CPU bus strobes and a VDP-style REQ/ACK register port. It synchronises and deglitches the read/write chip-select strobes, captures port address and data, and queues accesses in an ordered FIFO. It issues them to the core with a held REQ/ACK handshake and returns read data for the CPU data-bus driver. It replaces single-shot, unbuffered strobe-to-pulse capture, adding configurable address width, filter length and queue depth, back-pressure, and error flags.

## Interface
- ADDR_WIDTH, 2: port address bits captured per access.
- DATA_WIDTH, 8: CPU data width.
- FILTER_LEN, 3: consecutive agreeing synchronised samples needed to change a filtered strobe (≥1).
- FIFO_DEPTH, 4: access queue entries (power of two, ≥2).

Ports:
- clk  in  1  core clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- csr_n  in  1  raw asynchronous read strobe, active low.
- csw_n  in  1  raw asynchronous write strobe, active low.
- port_addr  in  ADDR_WIDTH  CPU port address, stable while a strobe is low.
- bus_din  in  DATA_WIDTH  CPU write data, stable while csw_n is low.
- bus_dout  out  DATA_WIDTH  last completed read data.
- req  out  1  access request to core, held until ack.
- wrt  out  1  1 = write, 0 = read; valid while req.
- adr  out  ADDR_WIDTH  access address; valid while req.
- dbo  out  DATA_WIDTH  write data; valid while req.
- ack  in  1  core accepts the access in any cycle where req & ack.
- dbi  in  DATA_WIDTH  core read data; valid in the req & ack cycle of a read.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries, excluding the one in flight.
- overflow  out  1  sticky: an access was dropped because the FIFO was full.
- proto_err  out  1  sticky: both filtered strobes fell in the same cycle.

## Operation
- **Synchroniser.** Each strobe passes through a 2-flop synchroniser, then a filter. The filtered value changes only after FILTER_LEN consecutive synchronised samples differ from it. Synchroniser and filter flops reset to 1.
- **Edge detect.**
  - Access event = filtered strobe 1→0.
  - The edge detector arms only after the filtered strobe has been seen high once after reset. A strobe held low through reset release does not create an access.
- **Capture.** In the event cycle, sample port_addr, bus_din (writes only) and type. Push {type, addr, data} into the FIFO. Reads and writes share the FIFO, so program order is preserved and a read never overtakes an earlier write.
- **Both strobes at once.** If both strobes fall in the same cycle, push nothing and set proto_err.
- **FIFO full.**
  - A push while full with no pop in the same cycle is dropped, and overflow is set.
  - A push and pop in the same cycle while full is accepted; the level is unchanged.
- **Issue FSM:**
  - IDLE:
    - Outputs: req=0.
    - If the FIFO is not empty: pop the head into the adr/dbo/wrt registers, set req=1, go to ISSUE.
  - ISSUE:
    - Outputs: req=1, with wrt/adr/dbo held constant.
    - On ack: req=0 next cycle; if the access is a read, load dbi into bus_dout; go to IDLE.
  - There is at least one req=0 cycle between consecutive accesses.
- **bus_dout** changes only on read completion. A dropped read leaves it unchanged.
- **Reset values:** req, wrt, adr, dbo, bus_dout, fifo_level, overflow and proto_err are all 0. FSM state is IDLE and the FIFO is empty.

## Timing
- The raw strobe is first sampled low at edge 1.
  - The filtered strobe falls at edge 2+FILTER_LEN.
  - The push happens at edge 3+FILTER_LEN.
  - With the FSM idle and the FIFO empty, req rises at edge 4+FILTER_LEN (edge 7 for the default).
- A strobe glitch shorter than FILTER_LEN cycles (after synchronisation) causes no access.
- Read completion: bus_dout is valid from the edge after the req & ack cycle. The CPU read cycle must span the full read latency; the bridge does not stall the CPU.
- ack asserted while req=0 is ignored.
- Throughput: one access per 2 cycles when ack is tied high.
- Reset asserted mid-ISSUE: req drops immediately, the in-flight and queued accesses are discarded, and the sticky flags clear.

## Test plan
- **Single write:** csw_n low 10 cycles, port_addr=1, bus_din=0xA5, ack tied high → req=1, wrt=1, adr=1, dbo=0xA5 for exactly 1 cycle, rising at edge 7.
- **Read after writes:** write 0x11 to port 0, then read port 1 while the core holds ack low 5 cycles; core returns dbi=0x3C → write completes before the read issues; bus_dout=0x3C after the read ack.
- **Glitch rejection:** 2-cycle csw_n low pulse with FILTER_LEN=3 → no req, fifo_level stays 0.
- **Overflow:** ack held low, 6 writes (0x01..0x06) with FIFO_DEPTH=4 → one in flight and 4 queued; the 6th is dropped and overflow=1; releasing ack yields writes 0x01..0x05 in order.
- **Illegal access:** csr_n and csw_n fall together → proto_err=1, no req.
- **Reset mid-access:** reset pulsed during ISSUE with 3 entries queued → req=0 immediately, fifo_level=0; csw_n held low across reset release causes no access until it rises and falls again.
